// File: rtl/bsg_serial_in_parallel_out_passthrough_dynamic_pkg.sv
// rtl/bsg_serial_in_parallel_out_passthrough_dynamic_pkg.sv - shared helpers for the dynamic SIPO gearbox
`ifndef BSG_ABSTRACT_MODULE
`define BSG_ABSTRACT_MODULE(fn)
`endif

package bsg_serial_in_parallel_out_passthrough_dynamic_pkg;

    // Width that stays legal (>=1) even when only one value must be encoded.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_array_reverse.sv
// rtl/bsg_array_reverse.sv - reverses element order of a packed array
module bsg_array_reverse #(
    parameter int width_p = 1,
    parameter int els_p   = 1
) (
    input  logic [els_p-1:0][width_p-1:0] i,
    output logic [els_p-1:0][width_p-1:0] o
);

    for (genvar k = 0; k < els_p; k++) begin : g_rev
        assign o[k] = i[els_p-1-k];
    end

endmodule

// File: rtl/bsg_counter_clear_up.sv
// rtl/bsg_counter_clear_up.sv - up counter with synchronous clear, clear wins over up
module bsg_counter_clear_up
    import bsg_serial_in_parallel_out_passthrough_dynamic_pkg::*;
#(
    parameter int max_val_p = 1,
    localparam int width_lp = safe_clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    logic [width_lp-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i) begin
            count_d = count_q + width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_dff_en.sv
// rtl/bsg_dff_en.sv - enabled data register without reset
module bsg_dff_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q, data_d;

    always_comb begin
        data_d = en_i ? data_i : data_q;
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_serial_in_parallel_out_passthrough_dynamic.sv
// rtl/bsg_serial_in_parallel_out_passthrough_dynamic.sv - variable-length SIPO with combinational last word
`BSG_ABSTRACT_MODULE(bsg_serial_in_parallel_out_passthrough_dynamic)

module bsg_serial_in_parallel_out_passthrough_dynamic
    import bsg_serial_in_parallel_out_passthrough_dynamic_pkg::*;
#(
    parameter int width_p    = 8,
    parameter int max_els_p  = 4,
    parameter int hi_to_lo_p = 0,
    localparam int lg_max_els_lp = safe_clog2(max_els_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_and_o,
    input  logic [width_p-1:0]             data_i,
    input  logic [lg_max_els_lp-1:0]       len_i,
    output logic [max_els_p*width_p-1:0]   data_o,
    output logic [lg_max_els_lp-1:0]       len_o,
    output logic                           v_o,
    input  logic                           ready_and_i
);

    if (max_els_p == 1) begin : g_passthrough
        logic unused_sigs;
        assign unused_sigs = ^{clk_i, len_i};
        assign data_o      = data_i;
        assign len_o       = '0;
        assign v_o         = v_i & ~reset_i;
        assign ready_and_o = ready_and_i & ~reset_i;
    end else begin : g_sipo
        localparam logic [lg_max_els_lp-1:0] max_len_lp = lg_max_els_lp'(max_els_p - 1);

        logic [lg_max_els_lp-1:0] count_lo, len_q, len_d, len_cur;
        logic last, accept, up, clear;
        logic [max_els_p-2:0][width_p-1:0] data_r;
        logic [max_els_p-1:0][width_p-1:0] data_lo, data_ord;

        always_comb begin
            len_cur     = (count_lo == '0) ? len_i : len_q;
            last        = (count_lo == len_cur);
            v_o         = v_i & last & ~reset_i;
            ready_and_o = ~reset_i & (~last | ready_and_i);
            accept      = v_i & ready_and_o;
            up          = accept & ~last;
            clear       = accept & last;
            len_d       = (accept && count_lo == '0) ? len_i : len_q;
            len_o       = len_cur;
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                len_q <= '0;
            end else begin
                len_q <= len_d;
            end
        end

        bsg_counter_clear_up #(.max_val_p(max_els_p - 1)) u_count (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .clear_i (clear),
            .up_i    (up),
            .count_o (count_lo)
        );

        // The final slot never needs storage: it is always the word in flight.
        for (genvar k = 0; k < max_els_p - 1; k++) begin : g_slot
            bsg_dff_en #(.width_p(width_p)) u_word (
                .clk_i  (clk_i),
                .en_i   (up && (count_lo == lg_max_els_lp'(k))),
                .data_i (data_i),
                .data_o (data_r[k])
            );
            assign data_lo[k] = (count_lo == lg_max_els_lp'(k)) ? data_i : data_r[k];
        end
        assign data_lo[max_els_p-1] = data_i;

        if (hi_to_lo_p != 0) begin : g_rev
            bsg_array_reverse #(.width_p(width_p), .els_p(max_els_p)) u_rev (
                .i (data_lo),
                .o (data_ord)
            );
        end else begin : g_fwd
            assign data_ord = data_lo;
        end
        assign data_o = data_ord;

        a_len_legal: assert property (@(posedge clk_i) disable iff (reset_i)
            (v_i && count_lo == '0) |-> (len_i <= max_len_lp));
    end

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_passthrough_dynamic.sv
// tb/tb_bsg_serial_in_parallel_out_passthrough_dynamic.sv - directed bench for the dynamic SIPO gearbox
module tb_bsg_serial_in_parallel_out_passthrough_dynamic;

    logic        clk_i = 1'b0;
    logic        reset_i, v_i, ready_and_i;
    logic [7:0]  data_i;
    logic [1:0]  len_i;
    logic        ready_and_o, v_o, ready_and_o_r, v_o_r;
    logic [31:0] data_o, data_o_r;
    logic [1:0]  len_o, len_o_r;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk_i = ~clk_i;

    bsg_serial_in_parallel_out_passthrough_dynamic #(.width_p(8), .max_els_p(4), .hi_to_lo_p(0)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o), .data_i(data_i),
        .len_i(len_i), .data_o(data_o), .len_o(len_o), .v_o(v_o), .ready_and_i(ready_and_i));

    bsg_serial_in_parallel_out_passthrough_dynamic #(.width_p(8), .max_els_p(4), .hi_to_lo_p(1)) dut_r (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o_r), .data_i(data_i),
        .len_i(len_i), .data_o(data_o_r), .len_o(len_o_r), .v_o(v_o_r), .ready_and_i(ready_and_i));

    // Inputs change 1ns after a rising edge; checks happen mid-cycle.
    task automatic drive(input logic v, input logic [1:0] len, input logic [7:0] d, input logic rdy);
        v_i = v; len_i = len; data_i = d; ready_and_i = rdy;
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        drive(1'b1, 2'd0, 8'hFF, 1'b1);
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        n_vec++; if (ready_and_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready_and_o); end
        next_cycle(); next_cycle();
        reset_i = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        next_cycle();
    endtask

    task automatic test_single_word();
        logic [7:0] words [2] = '{8'hA1, 8'hA2};
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'd0, words[k], 1'b1);
            n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL single_v_o[%0d] got=%b exp=1", k, v_o); end
            n_vec++; if (data_o[7:0] !== words[k]) begin n_err++; $display("FAIL single_data[%0d] got=%h exp=%h", k, data_o[7:0], words[k]); end
            n_vec++; if (len_o !== 2'd0) begin n_err++; $display("FAIL single_len[%0d] got=%0d exp=0", k, len_o); end
            n_vec++; if (ready_and_o !== 1'b1) begin n_err++; $display("FAIL single_ready[%0d] got=%b exp=1", k, ready_and_o); end
            next_cycle();
        end
    endtask

    task automatic test_full_packet();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd3, 8'h10 + 8'(k), 1'b1);
            n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL full_v_o_early[%0d] got=%b exp=0", k, v_o); end
            n_vec++; if (ready_and_o !== 1'b1) begin n_err++; $display("FAIL full_ready[%0d] got=%b exp=1", k, ready_and_o); end
            next_cycle();
        end
        drive(1'b1, 2'd3, 8'h13, 1'b1);
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL full_v_o got=%b exp=1", v_o); end
        n_vec++; if (data_o !== 32'h13121110) begin n_err++; $display("FAIL full_data got=%h exp=13121110", data_o); end
        n_vec++; if (len_o !== 2'd3) begin n_err++; $display("FAIL full_len got=%0d exp=3", len_o); end
        next_cycle();
        // Counter back at zero: a one-word packet must pass straight through.
        drive(1'b1, 2'd0, 8'h5A, 1'b1);
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL full_after_v_o got=%b exp=1", v_o); end
        n_vec++; if (data_o[7:0] !== 8'h5A) begin n_err++; $display("FAIL full_after_data got=%h exp=5a", data_o[7:0]); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'd2, 8'h20 + 8'(k), 1'b0);
            n_vec++; if (ready_and_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_nonlast[%0d] got=%b exp=1", k, ready_and_o); end
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd2, 8'h22, 1'b0);
            n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL bp_v_o[%0d] got=%b exp=1", k, v_o); end
            n_vec++; if (ready_and_o !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got=%b exp=0", k, ready_and_o); end
            n_vec++; if (data_o[23:0] !== 24'h222120) begin n_err++; $display("FAIL bp_data[%0d] got=%h exp=222120", k, data_o[23:0]); end
            n_vec++; if (len_o !== 2'd2) begin n_err++; $display("FAIL bp_len[%0d] got=%0d exp=2", k, len_o); end
            next_cycle();
        end
        drive(1'b1, 2'd2, 8'h22, 1'b1);
        n_vec++; if (ready_and_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", ready_and_o); end
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL bp_release_v_o got=%b exp=1", v_o); end
        next_cycle();
        drive(1'b1, 2'd0, 8'h60, 1'b1);
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL bp_next_v_o got=%b exp=1", v_o); end
        n_vec++; if (data_o[7:0] !== 8'h60) begin n_err++; $display("FAIL bp_next_data got=%h exp=60", data_o[7:0]); end
        next_cycle();
    endtask

    task automatic test_hi_to_lo();
        drive(1'b1, 2'd1, 8'h30, 1'b1);
        n_vec++; if (v_o_r !== 1'b0) begin n_err++; $display("FAIL rev_v_o_first got=%b exp=0", v_o_r); end
        next_cycle();
        drive(1'b1, 2'd1, 8'h31, 1'b1);
        n_vec++; if (v_o_r !== 1'b1) begin n_err++; $display("FAIL rev_v_o got=%b exp=1", v_o_r); end
        n_vec++; if (data_o_r[31:24] !== 8'h30) begin n_err++; $display("FAIL rev_slot3 got=%h exp=30", data_o_r[31:24]); end
        n_vec++; if (data_o_r[23:16] !== 8'h31) begin n_err++; $display("FAIL rev_slot2 got=%h exp=31", data_o_r[23:16]); end
        n_vec++; if (len_o_r !== 2'd1) begin n_err++; $display("FAIL rev_len got=%0d exp=1", len_o_r); end
        next_cycle();
    endtask

    task automatic test_reset_mid_packet();
        drive(1'b1, 2'd3, 8'h40, 1'b1); next_cycle();
        drive(1'b1, 2'd3, 8'h41, 1'b1); next_cycle();
        reset_i = 1'b1;
        drive(1'b1, 2'd3, 8'h42, 1'b1);
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL midrst_v_o got=%b exp=0", v_o); end
        n_vec++; if (ready_and_o !== 1'b0) begin n_err++; $display("FAIL midrst_ready got=%b exp=0", ready_and_o); end
        next_cycle();
        reset_i = 1'b0;
        drive(1'b1, 2'd0, 8'h50, 1'b1);
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL midrst_after_v_o got=%b exp=1", v_o); end
        n_vec++; if (data_o[7:0] !== 8'h50) begin n_err++; $display("FAIL midrst_after_data got=%h exp=50", data_o[7:0]); end
        n_vec++; if (len_o !== 2'd0) begin n_err++; $display("FAIL midrst_after_len got=%0d exp=0", len_o); end
        next_cycle();
    endtask

    task automatic test_gaps_and_lengths();
        drive(1'b1, 2'd2, 8'h70, 1'b1);
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL gap_v_o_w0 got=%b exp=0", v_o); end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 2'd0, 8'hEE, 1'b1);
            n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL gap_idle_v_o[%0d] got=%b exp=0", k, v_o); end
            n_vec++; if (len_o !== 2'd2) begin n_err++; $display("FAIL gap_idle_len[%0d] got=%0d exp=2", k, len_o); end
            next_cycle();
        end
        // len_i deliberately wrong on non-first words; it must be ignored.
        drive(1'b1, 2'd0, 8'h71, 1'b1);
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL gap_v_o_w1 got=%b exp=0", v_o); end
        next_cycle();
        drive(1'b1, 2'd1, 8'h72, 1'b1);
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL gap_v_o_w2 got=%b exp=1", v_o); end
        n_vec++; if (len_o !== 2'd2) begin n_err++; $display("FAIL gap_len got=%0d exp=2", len_o); end
        n_vec++; if (data_o[23:0] !== 24'h727170) begin n_err++; $display("FAIL gap_data got=%h exp=727170", data_o[23:0]); end
        next_cycle();
        drive(1'b1, 2'd1, 8'h80, 1'b1);
        n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL mix_v_o_w0 got=%b exp=0", v_o); end
        n_vec++; if (len_o !== 2'd1) begin n_err++; $display("FAIL mix_len_w0 got=%0d exp=1", len_o); end
        next_cycle();
        drive(1'b1, 2'd3, 8'h81, 1'b1);
        n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL mix_v_o_w1 got=%b exp=1", v_o); end
        n_vec++; if (len_o !== 2'd1) begin n_err++; $display("FAIL mix_len_w1 got=%0d exp=1", len_o); end
        n_vec++; if (data_o[15:0] !== 16'h8180) begin n_err++; $display("FAIL mix_data got=%h exp=8180", data_o[15:0]); end
        next_cycle();
        drive(1'b0, 2'd0, 8'h00, 1'b1);
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; ready_and_i = 1'b0; data_i = '0; len_i = '0;
        #1;
        test_reset();
        test_single_word();
        test_full_packet();
        test_backpressure();
        test_hi_to_lo();
        test_reset_mid_packet();
        test_gaps_and_lengths();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
